adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_ctrl
// Description : Sequential WIDTH-bit adder built from one reused 4-bit ripple
//               slice. An accepted request is processed one nibble per cycle,
//               LSB nibble first, and the result is held until the consumer
//               takes it with a valid/ready handshake.
//               Optional feature macro: ADDER_SEQ_CTRL_SUB_EN
//               (defined: op_sub=1 selects op_a - op_b; undefined: op_sub is
//               ignored and the block always adds).
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_nibble: 4-bit ripple-carry slice, the only adder in this design.
// ----------------------------------------------------------------------------
module adder_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    // One full adder per bit; carry ripples upward through w_c.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            assign s[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co = w_c[4];

endmodule

// ----------------------------------------------------------------------------
// adder_seq_ctrl: IDLE / RUN / DONE controller around the nibble slice.
// ----------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int WIDTH = 16        // operand width, multiple of 4, >= 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Number of nibble passes and the width of the pass index.
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;          // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [IDXW+1:0]  w_base;       // bit offset of the current nibble
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s;
    logic             w_co;

`ifdef ADDER_SEQ_CTRL_SUB_EN
    // Subtraction is A + ~B + 1; the forced carry-in replaces op_cin.
    assign w_b_eff   = op_sub ? ~op_b : op_b;
    assign w_cin_eff = op_sub ? 1'b1  : op_cin;
`else
    // Add-only build: op_sub is kept on the port but has no effect.
    logic w_unused_op_sub;
    assign w_unused_op_sub = op_sub;
    assign w_b_eff         = op_b;
    assign w_cin_eff       = op_cin;
`endif

    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];

    adder_nibble u_slice (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .cin (r_carry),
        .s   (w_s),
        .co  (w_co)
    );

    // Controller FSM: capture in IDLE, one nibble per cycle in RUN, hold in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= w_b_eff;
                        r_carry    <= w_cin_eff;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    // Earlier result stays visible in the nibbles not yet rewritten.
                    r_sum[w_base +: 4] <= w_s;
                    r_carry            <= w_co;
                    if (r_idx == C_LAST_IDX) begin
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here, so the handshake cycle never accepts.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_seq_ctrl
// Description : Directed self-checking bench for adder_seq_ctrl (WIDTH=16).
//               Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_assert = 0;
    int n_fail   = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request, let it be accepted, then scramble the operands.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a     = 16'hDEAD;
        op_b     = 16'hBEEF;
        op_cin   = ~cin;
        op_sub   = ~sub;
    endtask

    // Count edges until out_valid; -1 if it never rises within the budget.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_sum",       32'(sum),       32'h0);
        check("reset_cout",      32'(cout),      32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", 32'(in_ready), 32'h1);

        // 0x1234 + 0x0FFF = 0x2233; result due 4 edges after the accepting edge.
        start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        check("t1_in_ready_busy", 32'(in_ready),  32'h0);
        check("t1_out_valid_low", 32'(out_valid), 32'h0);
        tick();
        check("t1_nibble0_written", 32'(sum), 32'h0003);
        wait_valid(lat);
        check("t1_latency", 32'(lat),  32'd3);
        check("t1_sum",     32'(sum),  32'h2233);
        check("t1_cout",    32'(cout), 32'h0);
        tick();
        check("t1_back_idle_valid", 32'(out_valid), 32'h0);
        check("t1_back_idle_ready", 32'(in_ready),  32'h1);
        check("t1_sum_retained",    32'(sum),       32'h2233);

        // 0xFFFF + 0x0000 + 1: carry ripples through every pass.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        tick();
        check("t2_nibble0_over_old", 32'(sum), 32'h2230);
        wait_valid(lat);
        check("t2_latency", 32'(lat),  32'd3);
        check("t2_sum",     32'(sum),  32'h0000);
        check("t2_cout",    32'(cout), 32'h1);

        // 0x8000 + 0x8000 + 1 = 0x1_0001.
        tick();
        start_op(16'h8000, 16'h8000, 1'b1, 1'b0);
        wait_valid(lat);
        check("t3_latency", 32'(lat),  32'd4);
        check("t3_sum",     32'(sum),  32'h0001);
        check("t3_cout",    32'(cout), 32'h1);

        // Backpressure: result held while a competing request waits.
        tick();
        out_ready = 1'b0;
        start_op(16'h00F0, 16'h0010, 1'b0, 1'b0);
        wait_valid(lat);
        check("t4_latency", 32'(lat), 32'd4);
        held     = sum;
        check("t4_sum", 32'(held), 32'h0100);
        op_a     = 16'h1111;
        op_b     = 16'h1111;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_ready", 32'(in_ready),  32'h0);
            check("t4_hold_sum",   32'(sum),       32'h0100);
        end
        out_ready = 1'b1;
        tick();
        check("t4_handshake_idle",  32'(out_valid), 32'h0);
        check("t4_no_same_accept",  32'(in_ready),  32'h1);
        tick();
        in_valid = 1'b0;
        op_a     = 16'h0;
        op_b     = 16'h0;
        check("t4_accept_after_idle", 32'(in_ready), 32'h0);
        wait_valid(lat);
        check("t4_second_latency", 32'(lat), 32'd4);
        check("t4_second_sum",     32'(sum), 32'h2222);
        tick();

        // Reset while in RUN with idx=2 aborts the operation.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_reset_sum",   32'(sum),       32'h0);
        check("t5_reset_valid", 32'(out_valid), 32'h0);
        check("t5_reset_cout",  32'(cout),      32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_valid_after_abort", 32'(out_valid), 32'h0);
        end
        check("t5_idle_ready", 32'(in_ready), 32'h1);

        // op_sub request: subtract when the feature is built in, add otherwise.
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_valid(lat);
        check("t6_latency", 32'(lat), 32'd4);
`ifdef ADDER_SEQ_CTRL_SUB_EN
        check("t6_sub_sum",  32'(sum),  32'hFFFE);
        check("t6_sub_cout", 32'(cout), 32'h0);
`else
        check("t6_nosub_sum",  32'(sum),  32'h000C);
        check("t6_nosub_cout", 32'(cout), 32'h0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
